// File: rtl/one_hot_state_decoder_pkg.sv
// one_hot_state_decoder_pkg: shared FSM encodings and index-width helper for the one-hot state decoder
package one_hot_state_decoder_pkg;
  typedef enum logic [1:0] {WAIT, TRACK, FAULT} state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/one_hot_state_decoder_if.sv
// one_hot_state_decoder_if: one-hot state vector in, decoded status out
interface one_hot_state_decoder_if #(
  parameter int N_STATES = 8,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = one_hot_state_decoder_pkg::idx_w(N_STATES);
  logic [N_STATES-1:0] state_vec;
  logic [IDX_W-1:0]    enc_state;
  logic                valid;
  logic                trans;
  logic [CNT_W-1:0]    dwell_cnt;
  logic                err_none;
  logic                err_multi;
  logic                err_sticky;
  logic                rearm;
  modport master (output state_vec, input enc_state, valid, trans, dwell_cnt, err_none, err_multi, err_sticky, rearm);
  modport slave  (input state_vec, output enc_state, valid, trans, dwell_cnt, err_none, err_multi, err_sticky, rearm);
endinterface

// File: rtl/one_hot_state_decoder_enc.sv
// onehot_encoder: combinational index, empty and multi-hot detection of a sampled one-hot vector
module onehot_encoder
  import one_hot_state_decoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         samp,
  output logic [idx_w(N)-1:0]  idx,
  output logic                 zero,
  output logic                 multi
);
  assign zero  = ~|samp;
  assign multi = |(samp & (samp - N'(1)));
  // lowest set bit wins; only meaningful when exactly one bit is set
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (samp[i]) idx = i[idx_w(N)-1:0];
  end
endmodule

// File: rtl/one_hot_state_decoder.sv
// one_hot_state_decoder: samples the one-hot chain, encodes it, times dwell and flags illegal vectors (ONE_HOT_RECOVER_EN adds a re-arm pulse)
module one_hot_state_decoder
  import one_hot_state_decoder_pkg::*;
#(
  parameter int N_STATES = 8,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst_n,
  one_hot_state_decoder_if.slave bus
);
  localparam int IDX_W = idx_w(N_STATES);
  logic [N_STATES-1:0] samp;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    enc_d;
  logic [CNT_W-1:0]    dwell_d;
  logic                zero;
  logic                multi;
  logic                legal;
  logic                trans_d;
  state_t              state;
  state_t              state_d;

  onehot_encoder #(.N(N_STATES)) u_enc (
    .samp  (samp),
    .idx   (idx),
    .zero  (zero),
    .multi (multi)
  );

  assign legal = !zero && !multi;

  // next state, index and dwell; index and dwell hold while the sample is illegal
  always_comb begin
    state_d = state;
    enc_d   = bus.enc_state;
    dwell_d = bus.dwell_cnt;
    trans_d = 1'b0;
    if (legal) begin
      state_d = TRACK;
      enc_d   = idx;
      trans_d = (state != WAIT) && (idx != bus.enc_state);
      dwell_d = (state == TRACK && !trans_d) ? ((&bus.dwell_cnt) ? bus.dwell_cnt : bus.dwell_cnt + CNT_W'(1)) : '0;
    end else if (state != WAIT) begin
      state_d = FAULT;
    end
  end

  // sample stage then registered status stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp           <= '0;
      state          <= WAIT;
      bus.enc_state  <= '0;
      bus.valid      <= 1'b0;
      bus.trans      <= 1'b0;
      bus.dwell_cnt  <= '0;
      bus.err_none   <= 1'b0;
      bus.err_multi  <= 1'b0;
      bus.err_sticky <= 1'b0;
    end else begin
      samp           <= bus.state_vec;
      state          <= state_d;
      bus.enc_state  <= enc_d;
      bus.valid      <= legal;
      bus.trans      <= trans_d;
      bus.dwell_cnt  <= dwell_d;
      bus.err_none   <= zero;
      bus.err_multi  <= multi;
      bus.err_sticky <= bus.err_sticky | zero | multi;
    end
  end

`ifdef ONE_HOT_RECOVER_EN
  // single pulse on TRACK->FAULT; FAULT is only reachable from TRACK so it cannot re-fire without a legal sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rearm <= 1'b0;
    else bus.rearm <= (state == TRACK) && !legal;
  end
`else
  assign bus.rearm = 1'b0;
`endif
endmodule

// File: tb/tb_one_hot_state_decoder.sv
// tb_one_hot_state_decoder: directed self-checking bench for one_hot_state_decoder
module tb_one_hot_state_decoder;
`ifdef ONE_HOT_RECOVER_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif
  logic clk;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  one_hot_state_decoder_if #(.N_STATES(8), .CNT_W(8)) a ();
  one_hot_state_decoder_if #(.N_STATES(8), .CNT_W(4)) b ();

  one_hot_state_decoder #(.N_STATES(8), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  one_hot_state_decoder #(.N_STATES(8), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [2:0] e, input logic t,
                       input logic [7:0] d, input logic n, input logic m, input logic s);
    chk($sformatf("%s.valid", tag), 32'(a.valid), 32'(v));
    chk($sformatf("%s.enc", tag), 32'(a.enc_state), 32'(e));
    chk($sformatf("%s.trans", tag), 32'(a.trans), 32'(t));
    chk($sformatf("%s.dwell", tag), 32'(a.dwell_cnt), 32'(d));
    chk($sformatf("%s.none", tag), 32'(a.err_none), 32'(n));
    chk($sformatf("%s.multi", tag), 32'(a.err_multi), 32'(m));
    chk($sformatf("%s.sticky", tag), 32'(a.err_sticky), 32'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a.state_vec = 8'h01;
    b.state_vec = 8'h08;
    #12;
    chk_a("rst", 0, 0, 0, 0, 0, 0, 0);
    chk("rst.rearm", 32'(a.rearm), 0);
    chk("rst.b_dwell", 32'(b.dwell_cnt), 0);
    rst_n = 1'b1;
    tick();
    chk_a("t1e1", 0, 0, 0, 0, 1, 0, 1);
    tick();
    chk_a("t1e2", 1, 0, 0, 0, 0, 0, 1);
    for (int d = 1; d <= 3; d++) begin
      tick();
      chk_a($sformatf("t1d%0d", d), 1, 0, 0, 8'(d), 0, 0, 1);
    end
    a.state_vec = 8'h02;
    tick();
    chk_a("t2e6", 1, 0, 0, 4, 0, 0, 1);
    tick();
    chk_a("t2e7", 1, 1, 1, 0, 0, 0, 1);
    tick();
    chk_a("t2e8", 1, 1, 0, 1, 0, 0, 1);
    a.state_vec = 8'h04;
    tick();
    chk_a("t2e9", 1, 1, 0, 2, 0, 0, 1);
    tick();
    chk_a("t2e10", 1, 2, 1, 0, 0, 0, 1);
    tick();
    chk_a("t2e11", 1, 2, 0, 1, 0, 0, 1);
    a.state_vec = 8'h00;
    tick();
    chk_a("t3e12", 1, 2, 0, 2, 0, 0, 1);
    a.state_vec = 8'h04;
    tick();
    chk_a("t3e13", 0, 2, 0, 2, 1, 0, 1);
    chk("t3e13.rearm", 32'(a.rearm), 32'(REC));
    tick();
    chk_a("t3e14", 1, 2, 0, 0, 0, 0, 1);
    chk("t3e14.rearm", 32'(a.rearm), 0);
    a.state_vec = 8'h06;
    tick();
    chk_a("t4e15", 1, 2, 0, 1, 0, 0, 1);
    a.state_vec = 8'h01;
    tick();
    chk_a("t4e16", 0, 2, 0, 1, 0, 1, 1);
    chk("t4e16.rearm", 32'(a.rearm), 32'(REC));
    tick();
    chk_a("t4e17", 1, 0, 1, 0, 0, 0, 1);
    chk("t4e17.rearm", 32'(a.rearm), 0);
    tick();
    chk_a("t4e18", 1, 0, 0, 1, 0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("t6rst", 0, 0, 0, 0, 0, 0, 0);
    chk("t6rst.rearm", 32'(a.rearm), 0);
    chk("t6rst.b_dwell", 32'(b.dwell_cnt), 0);
    chk("t6rst.b_valid", 32'(b.valid), 0);
    #4;
    rst_n = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 1) chk_a("t6k1", 0, 0, 0, 0, 1, 0, 1);
      if (k == 2) chk_a("t6k2", 1, 0, 0, 0, 0, 0, 1);
      if (k == 5) chk_a("t6k5", 1, 0, 0, 3, 0, 0, 1);
      if (k == 16) chk("t5k16.b_dwell", 32'(b.dwell_cnt), 14);
      if (k == 17) chk("t5k17.b_dwell", 32'(b.dwell_cnt), 15);
      if (k == 22) begin
        chk("t5k22.b_dwell", 32'(b.dwell_cnt), 15);
        chk("t5k22.b_enc", 32'(b.enc_state), 3);
        chk("t5k22.b_valid", 32'(b.valid), 1);
        chk("t5k22.b_trans", 32'(b.trans), 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
